// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counter interrupt source. It supports a one-shot mode with a
// level IRQ and an auto-reload mode with a one-cycle pulse IRQ.
module timer_counter #(
    parameter int                CNT_W      = 32,
    parameter logic [CNT_W-1:0]  PRESET_RST = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_flag;
    logic             ctrl_wr;
    logic             preset_wr;
    logic             auto_reload;
    logic             im_rising;

    assign ctrl_wr     = We && (Addr == 2'd0);
    assign preset_wr   = We && (Addr == 2'd1);
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign IRQ         = irq_flag & ctrl[3];

    // A CTRL write that unmasks IRQ keeps a pending flag so the pending level becomes visible.
    // Every other CTRL or PRESET write acknowledges the flag.
    assign im_rising   = DIn[3] && !ctrl[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ctrl     <= 4'b0000;
            preset   <= PRESET_RST;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ctrl[0]) begin
                        count <= preset;
                        state <= S_CNT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count != '0) begin
                        count <= count - ONE;
                    end else begin
                        state    <= S_INT;
                        irq_flag <= 1'b1;
                    end
                end
                S_INT: begin
                    if (auto_reload) begin
                        state    <= S_LOAD;
                        irq_flag <= 1'b0;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Bus writes come last so they override the FSM's own CTRL and flag updates.
            if (ctrl_wr) begin
                ctrl <= DIn[3:0];
                if (!im_rising) begin
                    irq_flag <= 1'b0;
                end
            end
            if (preset_wr) begin
                preset   <= CNT_W'(DIn);
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (Addr)
            2'd0:    DOut = {28'd0, ctrl};
            2'd1:    DOut = 32'(preset);
            2'd2:    DOut = 32'(count);
            default: DOut = 32'd0;
        endcase
    end

endmodule
